// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int DSIZE_DEF   = 16;
    localparam int ASIZE_DEF   = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack port: the controller is the master, the memory the slave.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int AW    = ASIZE_DEF
);

    logic             dmem_req;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [DSIZE-1:0] dmem_wdata;
    logic             dmem_ack;
    logic [DSIZE-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Saturating wait counter; expired flags the MAX-th enabled cycle since the last clear.
module mem_timeout_cnt
    import mem_access_ctrl_pkg::*;
#(
    parameter int MAX = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(MAX + 1);
    localparam logic [CW-1:0] SAT  = CW'(MAX);
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts the ack-less cycles already spent, so this is the last allowed one
    assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per load/store and stalls upstream until it completes.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int AW      = ASIZE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memread_in,
    input  logic                memwrite_in,
    input  logic [DSIZE-1:0]    aluout_in,
    input  logic [DSIZE-1:0]    rdata2_in,
    output logic                stall,
    output logic [DSIZE-1:0]    rdata_out,
    output logic                mem_err,
    mem_access_ctrl_if.master   dmem
);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;

    logic mem_op;
    logic cnt_clr;
    logic cnt_en;
    logic expired;

    assign mem_op  = memread_in | memwrite_in;
    assign cnt_clr = (state_q == ST_IDLE);
    assign cnt_en  = (state_q == ST_ACCESS) & ~dmem.dmem_ack;

    mem_timeout_cnt #(
        .MAX (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous read and write request resolves to the write
                if (mem_op) begin
                    state_d = ST_ACCESS;
                    req_d   = 1'b1;
                    we_d    = memwrite_in;
                    addr_d  = aluout_in[AW-1:0];
                    wdata_d = rdata2_in;
                end
            end
            ST_ACCESS: begin
                if (dmem.dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = dmem.dmem_rdata;
                    end
                end else if (expired) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall covers the detect cycle in IDLE so EXE/MEM holds the op while it is outstanding
    assign stall = rst & (((state_q == ST_IDLE) & mem_op) | (state_q == ST_ACCESS));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign rdata_out       = rdata_q;
    assign mem_err         = err_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences data-memory accesses for the MEM stage and stalls the pipeline while an access is outstanding. Sits directly after the EXE/MEM pipeline register: consumes its `memread`/`memwrite`/`aluout`/`rdata2` outputs, drives a req/ack data-memory port, and returns load data toward MEM/WB. The `stall` output freezes PC, IF/ID, ID/EXE and EXE/MEM until the access completes.

## Interface
Parameters:
- `DSIZE`, 16, data width (matches `` `DSIZE ``)
- `AW`, 16, data-memory address width; low `AW` bits of `aluout_in`
- `TIMEOUT`, 15, max ACCESS cycles without ack before abort (≥1)

Ports:
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `memread_in`  in  1  load in EXE/MEM
- `memwrite_in`  in  1  store in EXE/MEM
- `aluout_in`  in  DSIZE  effective address
- `rdata2_in`  in  DSIZE  store data
- `stall`  out  1  freeze upstream stages and EXE/MEM
- `dmem_req`  out  1  access request, level
- `dmem_we`  out  1  1 = write, 0 = read
- `dmem_addr`  out  AW  access address
- `dmem_wdata`  out  DSIZE  write data
- `dmem_ack`  in  1  memory completes access (one-cycle pulse)
- `dmem_rdata`  in  DSIZE  read data, valid with `dmem_ack`
- `rdata_out`  out  DSIZE  load result to MEM/WB
- `mem_err`  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if `memread_in | memwrite_in`, register addr, wdata and `we = memwrite_in`, then go to ACCESS. Both asserted: write wins, no error.
- ACCESS: `dmem_req` = 1, with addr/we/wdata held stable.
  - On `dmem_ack`: capture `dmem_rdata` into `rdata_out` if read (unchanged on write), go to DONE.
  - If no ack by the end of the `TIMEOUT`-th ACCESS cycle: pulse `mem_err`, load `rdata_out` = 0, go to DONE.
- DONE: unconditionally go to IDLE. The pipeline advances on this edge, so the completed instruction is never reissued.
- `stall` (combinational) = (IDLE & (memread_in | memwrite_in)) | ACCESS. It is 0 in DONE.
- `dmem_ack` is ignored outside ACCESS.
- Timeout counter: clog2(TIMEOUT+1) bits, cleared on entry to ACCESS, increments each ACCESS cycle without ack, no wrap.
- `rdata_out` holds its value until the next completed load or timeout.

## Timing
- Reset (`rst` = 0, async): state IDLE, `dmem_req`/`dmem_we`/`mem_err` = 0, `dmem_addr`/`dmem_wdata`/`rdata_out`/counter = 0. `stall` is forced to 0 while `rst` is low.
- Reset mid-ACCESS drops `dmem_req` immediately and abandons the access. The memory must tolerate an abandoned request.
- Zero-wait memory (ack in first ACCESS cycle): 2 stall cycles (IDLE-detect, ACCESS), then DONE with `rdata_out` valid.
- N wait cycles: 2+N stall cycles.
- Timeout: `TIMEOUT`+1 stall cycles. `mem_err` is high during DONE only.
- Back-to-back memory ops: IDLE is re-entered after DONE, and the next op starts its detect cycle there. Minimum 3 cycles per access.
- Non-memory instructions: no stall, no `dmem_req`, zero added latency.

## Structure
- Shared package/define file: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and default `TIMEOUT`, alongside `` `DSIZE ``/`` `ASIZE ``.
- One natural sub-module: `mem_timeout_cnt`, a saturating counter with clear/enable and a `expired` output. The FSM and capture registers stay in `mem_access_ctrl`.

## Test plan
- Load, zero-wait: `memread_in`=1, `aluout_in`=16'h0040, ack in first ACCESS cycle with `dmem_rdata`=16'hBEEF -> `stall` high exactly 2 cycles, `dmem_addr`=16'h0040, `dmem_we`=0, `rdata_out`=16'hBEEF in DONE.
- Store, 3 wait cycles: `memwrite_in`=1, `rdata2_in`=16'h1234, ack on 4th ACCESS cycle -> `dmem_we`=1, `dmem_wdata`=16'h1234 stable while `dmem_req`=1, `stall` high 5 cycles, `rdata_out` unchanged.
- Timeout: load, no ack, TIMEOUT=15 -> `stall` high 16 cycles, `mem_err` pulse 1 cycle, `rdata_out`=0, `dmem_req` low after.
- Back-to-back load, store, ALU op -> accesses separated by DONE/IDLE, the ALU op adds no stall, and each access is issued exactly once.
- Async reset asserted during ACCESS -> `dmem_req`, `stall` and `mem_err` go to 0 without a clock edge, and the FSM is in IDLE after reset release.
- Stray `dmem_ack` in IDLE, plus `memread_in`=`memwrite_in`=1 -> stray ack ignored, write issued (`dmem_we`=1), no `mem_err`.
